dsp_mac_sequencer: RTL and testbench

Sequencer that drives a single DSP48A1 slice as an unsigned multiply-accumulate engine for dot products. It accepts a job length, streams operand pairs in over a valid/ready handshake, and emits OPMODE and clock-enable codes aligned to the slice's pipeline. It returns the 48-bit accumulated P once the slice pipeline has drained, and sits between the operand source and the DSP48A1 instance in the datapath top.

---
 rtl/dsp_ctrl_pkg.sv | 23 ++
 rtl/dsp_mac_sequencer.sv | 151 +++++++++++++++
 tb/tb_dsp_mac_sequencer.sv | 313 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dsp_ctrl_pkg.sv
// dsp_ctrl_pkg
// Shared constants and types for the DSP48A1 multiply-accumulate sequencer.
//   DSP_LAT     : cycles from DSP_A/DSP_B to DSP_P for the chosen slice register setup
//   OPM_*       : OPMODE codes driven into the slice (upper nibble always 0)
//   state_t     : sequencer FSM states
package dsp_ctrl_pkg;

    localparam int DSP_LAT = 3;

    // OPMODE[3:2] selects Z (00 = 0, 10 = P), OPMODE[1:0] selects X (00 = 0, 01 = M)
    localparam logic [7:0] OPM_CLEAR = 8'h00;
    localparam logic [7:0] OPM_FIRST = 8'h01;
    localparam logic [7:0] OPM_ACC   = 8'h09;
    localparam logic [7:0] OPM_HOLD  = 8'h08;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_t;

endpackage

// File: rtl/dsp_mac_sequencer.sv
// dsp_mac_sequencer
// Drives one DSP48A1 slice as an unsigned dot-product MAC engine. A job of
// cfg_len operand pairs is streamed in over s_valid/s_ready, issued to the
// slice with per-slot OPMODE codes, and the accumulated P is returned on
// r_valid/r_ready once the slice pipeline has drained.
// Ports:
//   CLK, RST_N           clock and asynchronous active-low reset
//   start, cfg_len       job request and pair count (sampled in IDLE only)
//   busy                 high outside IDLE
//   s_valid/s_ready      operand handshake, s_a/s_b unsigned 18-bit operands
//   r_valid/r_ready      result handshake, r_data taken straight from DSP_P
//   DSP_A, DSP_B         slice operands
//   DSP_OPMODE           slice OPMODE (registered one extra stage)
//   DSP_CE*              slice clock enables
//   DSP_P                slice accumulator output
module dsp_mac_sequencer
    import dsp_ctrl_pkg::*;
#(
    parameter int LEN_W = 8
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             start,
    input  logic [LEN_W-1:0] cfg_len,
    output logic             busy,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [17:0]      s_a,
    input  logic [17:0]      s_b,
    output logic             r_valid,
    input  logic             r_ready,
    output logic [47:0]      r_data,
    output logic [17:0]      DSP_A,
    output logic [17:0]      DSP_B,
    output logic [7:0]       DSP_OPMODE,
    output logic             DSP_CEA,
    output logic             DSP_CEB,
    output logic             DSP_CEM,
    output logic             DSP_CEOPMODE,
    output logic             DSP_CEP,
    input  logic [47:0]      DSP_P
);

    localparam int CNT_W = (DSP_LAT > 1) ? $clog2(DSP_LAT) : 1;

    state_t           state;
    state_t           state_next;
    logic [LEN_W-1:0] remaining;
    logic             first;
    logic [CNT_W-1:0] drain_cnt;
    logic [7:0]       slot_code;
    logic [7:0]       code_q;
    logic             ce_on;
    logic             take;

    assign take = (state == RUN) && s_valid;

    // Next state and the OPMODE code for the slot issued this cycle.
    // The first flag survives an empty job, so DRAIN uses it to keep
    // clearing P instead of holding whatever the previous job left.
    always_comb begin
        state_next = state;
        slot_code  = OPM_HOLD;
        case (state)
            IDLE: begin
                slot_code = OPM_CLEAR;
                if (start) begin
                    state_next = (cfg_len == '0) ? DRAIN : RUN;
                end
            end
            RUN: begin
                if (take) begin
                    slot_code = first ? OPM_FIRST : OPM_ACC;
                    if (remaining == LEN_W'(1)) begin
                        state_next = DRAIN;
                    end
                end
            end
            DRAIN: begin
                slot_code = first ? OPM_CLEAR : OPM_HOLD;
                if (drain_cnt == CNT_W'(DSP_LAT - 1)) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (r_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State, job bookkeeping and the operand/OPMODE pipeline into the slice.
    // DSP_A/DSP_B are loaded at the same edge as code_q; the extra code_q
    // stage lines the code up with the slot's product at the slice's P adder.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state      <= IDLE;
            remaining  <= '0;
            first      <= 1'b0;
            drain_cnt  <= '0;
            code_q     <= OPM_CLEAR;
            DSP_OPMODE <= OPM_CLEAR;
            DSP_A      <= '0;
            DSP_B      <= '0;
            ce_on      <= 1'b0;
        end else begin
            state      <= state_next;
            ce_on      <= 1'b1;
            code_q     <= slot_code;
            DSP_OPMODE <= code_q;

            if (state == IDLE && start) begin
                remaining <= cfg_len;
                first     <= 1'b1;
            end else if (take) begin
                remaining <= remaining - LEN_W'(1);
                first     <= 1'b0;
            end

            if (take) begin
                DSP_A <= s_a;
                DSP_B <= s_b;
            end else begin
                DSP_A <= '0;
                DSP_B <= '0;
            end

            if (state == DRAIN) begin
                drain_cnt <= drain_cnt + CNT_W'(1);
            end else begin
                drain_cnt <= '0;
            end
        end
    end

    assign busy    = (state != IDLE);
    assign s_ready = (state == RUN);
    assign r_valid = (state == DONE);
    assign r_data  = DSP_P;

    // Enables stay low until the first edge after reset; P is frozen while
    // the result is being presented.
    assign DSP_CEA      = ce_on;
    assign DSP_CEB      = ce_on;
    assign DSP_CEM      = ce_on;
    assign DSP_CEOPMODE = ce_on;
    assign DSP_CEP      = ce_on && (state != DONE);

endmodule

// File: tb/tb_dsp_mac_sequencer.sv
// tb_dsp_mac_sequencer
// Scoreboard bench for dsp_mac_sequencer. A behavioural DSP48A1 slice model
// closes the loop from DSP_A/DSP_B/DSP_OPMODE back to DSP_P. Each job's
// expected dot product (plain sum of products) and expected result cycle are
// queued when the job is issued; a monitor pops and compares whenever r_valid
// rises, and checks r_data stability and DSP_CEP while the result is held.
module tb_dsp_mac_sequencer;
    import dsp_ctrl_pkg::*;

    localparam int LEN_W = 8;

    logic             CLK = 1'b0;
    logic             RST_N = 1'b0;
    logic             start = 1'b0;
    logic [LEN_W-1:0] cfg_len = '0;
    logic             busy;
    logic             s_valid = 1'b0;
    logic             s_ready;
    logic [17:0]      s_a = '0;
    logic [17:0]      s_b = '0;
    logic             r_valid;
    logic             r_ready = 1'b0;
    logic [47:0]      r_data;
    logic [17:0]      DSP_A;
    logic [17:0]      DSP_B;
    logic [7:0]       DSP_OPMODE;
    logic             DSP_CEA;
    logic             DSP_CEB;
    logic             DSP_CEM;
    logic             DSP_CEOPMODE;
    logic             DSP_CEP;
    logic [47:0]      DSP_P;

    dsp_mac_sequencer #(.LEN_W(LEN_W)) dut (
        .CLK(CLK), .RST_N(RST_N), .start(start), .cfg_len(cfg_len), .busy(busy),
        .s_valid(s_valid), .s_ready(s_ready), .s_a(s_a), .s_b(s_b),
        .r_valid(r_valid), .r_ready(r_ready), .r_data(r_data),
        .DSP_A(DSP_A), .DSP_B(DSP_B), .DSP_OPMODE(DSP_OPMODE),
        .DSP_CEA(DSP_CEA), .DSP_CEB(DSP_CEB), .DSP_CEM(DSP_CEM),
        .DSP_CEOPMODE(DSP_CEOPMODE), .DSP_CEP(DSP_CEP), .DSP_P(DSP_P)
    );

    initial forever #5 CLK = ~CLK;

    // DSP48A1 slice model: A1/B1, M, OPMODE and P registers, RST* tied low.
    logic [17:0] sl_a1 = '0;
    logic [17:0] sl_b1 = '0;
    logic [35:0] sl_m = '0;
    logic [7:0]  sl_opm = '0;
    logic [47:0] sl_p = '0;
    logic [47:0] sl_x;
    logic [47:0] sl_z;

    assign sl_x  = (sl_opm[1:0] == 2'b01) ? {12'b0, sl_m} : 48'd0;
    assign sl_z  = (sl_opm[3:2] == 2'b10) ? sl_p : 48'd0;
    assign DSP_P = sl_p;

    always @(posedge CLK) begin
        if (DSP_CEA)      sl_a1  <= DSP_A;
        if (DSP_CEB)      sl_b1  <= DSP_B;
        if (DSP_CEM)      sl_m   <= 36'(sl_a1) * 36'(sl_b1);
        if (DSP_CEOPMODE) sl_opm <= DSP_OPMODE;
        if (DSP_CEP)      sl_p   <= sl_x + sl_z;
    end

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct {
        logic [47:0] data;
        int          cyc;
    } exp_t;

    exp_t        exp_q[$];
    logic [17:0] op_a[$];
    logic [17:0] op_b[$];
    int          errors = 0;
    int          checks = 0;
    int          stall_len = 0;

    task automatic check_output(input string name, input logic [47:0] got, input logic [47:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, required %0h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    task automatic fail_bound(input string name);
        checks++;
        errors++;
        $display("[TB] FAIL %s: bound expired at cycle %0d", name, cyc);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_output({tag, "_busy"}, 48'(busy), 48'd0);
        check_output({tag, "_s_ready"}, 48'(s_ready), 48'd0);
        check_output({tag, "_r_valid"}, 48'(r_valid), 48'd0);
        check_output({tag, "_dsp_a"}, 48'(DSP_A), 48'd0);
        check_output({tag, "_dsp_b"}, 48'(DSP_B), 48'd0);
        check_output({tag, "_opmode"}, 48'(DSP_OPMODE), 48'd0);
        check_output({tag, "_ce"}, 48'({DSP_CEA, DSP_CEB, DSP_CEM, DSP_CEOPMODE, DSP_CEP}), 48'd0);
    endtask

    // Result consumer: holds r_ready low for stall_len cycles of r_valid.
    initial begin
        int wait_cnt;
        wait_cnt = 0;
        forever begin
            @(negedge CLK);
            if (r_valid) begin
                r_ready = (wait_cnt >= stall_len);
                wait_cnt++;
            end else begin
                r_ready = 1'b0;
                wait_cnt = 0;
            end
        end
    end

    // Monitor: pops an expectation when r_valid rises, then checks the held result.
    initial begin
        bit          was_valid;
        logic [47:0] held;
        exp_t        e;
        was_valid = 1'b0;
        held = '0;
        forever begin
            @(negedge CLK);
            if (RST_N && r_valid) begin
                if (!was_valid) begin
                    if (exp_q.size() == 0) begin
                        fail_bound("unexpected_result");
                    end else begin
                        e = exp_q.pop_front();
                        check_output("r_data", r_data, e.data);
                        check_output("r_valid_cycle", 48'(cyc), 48'(e.cyc));
                    end
                    held = r_data;
                end else begin
                    check_output("r_data_stable", r_data, held);
                end
                check_output("cep_in_done", 48'(DSP_CEP), 48'd0);
            end
            was_valid = RST_N && r_valid;
        end
    end

    // Issues one job from op_a/op_b: gap bubbles before the second pair,
    // random bubbles, a result stall, and optionally a start pulse mid-job.
    task automatic apply_stimulus(input int len, input int gap, input int bubble_pct,
                                  input int stall, input bit poke_start);
        logic [47:0] sum;
        exp_t        e;
        int          idx, budget, start_cyc, last_cyc, gaps_done;
        bit          poked, bubble;
        sum = '0;
        gaps_done = 0;
        poked = 1'b0;
        last_cyc = 0;
        stall_len = stall;
        budget = 0;
        @(negedge CLK);
        while (busy && budget < 500) begin
            @(negedge CLK);
            budget++;
        end
        if (busy) begin
            fail_bound("idle_wait");
            return;
        end
        start = 1'b1;
        cfg_len = LEN_W'(len);
        start_cyc = cyc;
        @(negedge CLK);
        start = 1'b0;
        if (len == 0) begin
            e.data = '0;
            e.cyc = start_cyc + DSP_LAT + 1;
            exp_q.push_back(e);
        end
        idx = 0;
        budget = 0;
        while (idx < len && budget < 2000) begin
            bubble = 1'b0;
            if (idx == 1 && gaps_done < gap) begin
                bubble = 1'b1;
                gaps_done++;
            end else if (int'($urandom_range(99)) < bubble_pct) begin
                bubble = 1'b1;
            end
            s_valid = !bubble;
            s_a = bubble ? 18'd0 : op_a[idx];
            s_b = bubble ? 18'd0 : op_b[idx];
            if (poke_start && idx == 1 && !poked) begin
                start = 1'b1;
                cfg_len = LEN_W'(5);
                poked = 1'b1;
            end else begin
                start = 1'b0;
            end
            if (s_valid && s_ready) begin
                sum += 48'(op_a[idx]) * 48'(op_b[idx]);
                last_cyc = cyc;
                idx++;
            end
            @(negedge CLK);
            budget++;
        end
        s_valid = 1'b0;
        start = 1'b0;
        if (idx < len) begin
            fail_bound("accept_wait");
        end else if (len > 0) begin
            e.data = sum;
            e.cyc = last_cyc + DSP_LAT + 1;
            exp_q.push_back(e);
        end
        budget = 0;
        while ((exp_q.size() != 0 || r_valid || busy) && budget < 600) begin
            @(negedge CLK);
            budget++;
        end
        if (exp_q.size() != 0 || r_valid || busy) begin
            fail_bound("job_completion");
            exp_q.delete();
        end else begin
            checks++;
        end
    endtask

    task automatic load_pairs(input int n, input bit rnd, input logic [17:0] a, input logic [17:0] b);
        op_a.delete();
        op_b.delete();
        for (int i = 0; i < n; i++) begin
            op_a.push_back(rnd ? 18'($urandom) : a);
            op_b.push_back(rnd ? 18'($urandom) : b);
        end
    endtask

    initial begin
        int n, budget;
        #3;
        check_reset_outputs("reset");
        #10;
        RST_N = 1'b1;
        @(negedge CLK);
        check_output("ce_after_release", 48'({DSP_CEA, DSP_CEB, DSP_CEM, DSP_CEOPMODE, DSP_CEP}), 48'h1F);

        // Basic job: (2,3),(4,5),(6,7) -> 68
        op_a = '{18'd2, 18'd4, 18'd6};
        op_b = '{18'd3, 18'd5, 18'd7};
        apply_stimulus(3, 0, 0, 0, 1'b0);
        // Same job with a two-cycle gap
        apply_stimulus(3, 2, 0, 0, 1'b0);
        // Zero-length job right after P was left at 68
        apply_stimulus(0, 0, 0, 0, 1'b0);
        // Start pulsed while busy must be ignored
        apply_stimulus(3, 0, 0, 2, 1'b1);
        // Maximum length with maximum operands and a 10-cycle stall
        load_pairs(255, 1'b0, 18'h3FFFF, 18'h3FFFF);
        apply_stimulus(255, 0, 0, 10, 1'b0);

        // Mid-job reset after 2 of 4 pairs
        op_a = '{18'd11, 18'd12, 18'd13, 18'd14};
        op_b = '{18'd21, 18'd22, 18'd23, 18'd24};
        @(negedge CLK);
        start = 1'b1;
        cfg_len = LEN_W'(4);
        @(negedge CLK);
        start = 1'b0;
        n = 0;
        budget = 0;
        while (n < 2 && budget < 50) begin
            s_valid = 1'b1;
            s_a = op_a[n];
            s_b = op_b[n];
            if (s_ready) n++;
            @(negedge CLK);
            budget++;
        end
        s_valid = 1'b0;
        if (n < 2) fail_bound("reset_job_accept");
        #2;
        RST_N = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        repeat (2) @(negedge CLK);
        RST_N = 1'b1;
        @(negedge CLK);
        check_output("ce_after_mid_reset", 48'(DSP_CEP), 48'd1);
        load_pairs(1, 1'b0, 18'd10, 18'd10);
        apply_stimulus(1, 0, 0, 0, 1'b0);

        // Randomized jobs
        for (int j = 0; j < 8; j++) begin
            n = int'($urandom_range(12));
            load_pairs(n, 1'b1, '0, '0);
            apply_stimulus(n, int'($urandom_range(2)), 25, int'($urandom_range(4)), 1'b0);
        end

        repeat (3) @(negedge CLK);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
